// File: rtl/bench_seq_pkg.sv
// rtl/bench_seq_pkg.sv - shared types and constants for the sequence MISR bench
package bench_seq_pkg;

  typedef enum logic [1:0] {
    MODE_XOR  = 2'b00,
    MODE_MISR = 2'b01,
    MODE_LFSR = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } fsm_e;

  localparam logic [15:0] DEFAULT_POLY = 16'hB400;

endpackage

// File: rtl/bench_seq_next.sv
// rtl/bench_seq_next.sv - input fold and per-mode next-state function
module bench_seq_next
  import bench_seq_pkg::*;
#(
  parameter int                WIDTH    = 16,
  parameter int                IN_WIDTH = 18,
  parameter logic [WIDTH-1:0]  POLY     = WIDTH'(DEFAULT_POLY)
) (
  input  logic [WIDTH-1:0]    state,
  input  mode_e               mode,
  input  logic [IN_WIDTH-1:0] in,
  output logic [WIDTH-1:0]    next
);

  localparam int NSL = (IN_WIDTH + WIDTH - 1) / WIDTH;

  logic [NSL*WIDTH-1:0] padded;
  logic [WIDTH-1:0]     in_f;
  logic [WIDTH-1:0]     shifted;

  // Zero-pad the top slice so every slice is a full WIDTH bits before folding.
  always_comb begin
    padded = '0;
    padded[IN_WIDTH-1:0] = in;
    in_f = '0;
    for (int i = 0; i < NSL; i++) begin
      in_f = in_f ^ padded[i*WIDTH +: WIDTH];
    end
  end

  assign shifted = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? POLY : '0);

  always_comb begin
    next = state;
    unique case (mode)
      MODE_XOR:  next = state ^ in_f;
      MODE_MISR: next = shifted ^ in_f;
      MODE_LFSR: next = shifted;
      MODE_HOLD: next = state;
      default:   next = state;
    endcase
  end

endmodule

// File: rtl/bench_seq_misr.sv
// rtl/bench_seq_misr.sv - run-length controlled signature register with golden compare
module bench_seq_misr
  import bench_seq_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               IN_WIDTH  = 18,
  parameter int               OUT_WIDTH = 1,
  parameter int               CNT_WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY      = WIDTH'(DEFAULT_POLY)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [CNT_WIDTH-1:0] len,
  input  logic [WIDTH-1:0]     seed,
  input  logic [WIDTH-1:0]     expected,
  input  logic [IN_WIDTH-1:0]  in,
  output logic [OUT_WIDTH-1:0] out,
  output logic [WIDTH-1:0]     signature,
  output logic                 busy,
  output logic                 done,
  output logic                 pass
);

  fsm_e                 st, st_nx;
  mode_e                mode_q;
  logic [WIDTH-1:0]     state_q, exp_q, state_upd;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 load;

  bench_seq_next #(
    .WIDTH    (WIDTH),
    .IN_WIDTH (IN_WIDTH),
    .POLY     (POLY)
  ) u_next (
    .state (state_q),
    .mode  (mode_q),
    .in    (in),
    .next  (state_upd)
  );

  // start is only honoured outside RUN; a zero-length run lands directly in DONE.
  always_comb begin
    st_nx = st;
    load  = 1'b0;
    unique case (st)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load  = 1'b1;
          st_nx = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == CNT_WIDTH'(1)) st_nx = ST_DONE;
      end
      default: st_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= ST_IDLE;
      state_q <= '0;
      cnt     <= '0;
      mode_q  <= MODE_XOR;
      exp_q   <= '0;
    end else begin
      st <= st_nx;
      if (load) begin
        state_q <= seed;
        cnt     <= len;
        mode_q  <= mode_e'(mode);
        exp_q   <= expected;
      end else if (st == ST_RUN) begin
        state_q <= state_upd;
        cnt     <= cnt - CNT_WIDTH'(1);
      end
    end
  end

  assign out       = state_q[OUT_WIDTH-1:0];
  assign signature = state_q;
  assign busy      = (st == ST_RUN);
  assign done      = (st == ST_DONE);
  assign pass      = done && (state_q == exp_q);

endmodule

// File: doc/bench_seq_misr.md
BENCH_SEQ_MISR -- requirements
Module: bench_seq_misr

Interface
REQ-001 SHALL have parameter WIDTH, default 16, state/signature width (>=2).
REQ-002 SHALL have parameter IN_WIDTH, default 18, data input width (>=1).
REQ-003 SHALL have parameter OUT_WIDTH, default 1, observed output width (1..WIDTH).
REQ-004 SHALL have parameter CNT_WIDTH, default 8, run-length counter width.
REQ-005 SHALL have parameter POLY, default 16'hB400, Galois feedback taps (WIDTH bits).
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port start  input  1  begin a run (pulse).
REQ-009 SHALL have port mode  input  2  update mode, sampled with start.
REQ-010 SHALL have port len  input  CNT_WIDTH  number of updates, sampled with start.
REQ-011 SHALL have port seed  input  WIDTH  initial state, sampled with start.
REQ-012 SHALL have port expected  input  WIDTH  golden signature, sampled with start.
REQ-013 SHALL have port in  input  IN_WIDTH  data stimulus.
REQ-014 SHALL have port out  output  OUT_WIDTH  state[OUT_WIDTH-1:0], continuous.
REQ-015 SHALL have port signature  output  WIDTH  current state register.
REQ-016 SHALL have ports busy, done, pass  output  1 each  run / finished / signature match.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-018 start in IDLE or DONE SHALL load state<=seed, counter<=len, capture mode and expected, and go to RUN; go to DONE instead if len==0.
REQ-019 start, mode, len, seed and expected SHALL be ignored while in RUN.
REQ-020 Each edge in RUN SHALL perform one state update and decrement counter; the edge performing the len-th update SHALL go to DONE (done first visible len+1 cycles after start sampled).
REQ-021 in_f SHALL be the XOR of all WIDTH-bit slices of in, last slice zero-padded (IN_WIDTH<WIDTH: zero-extended).
REQ-022 Mode 00 XOR: next = state ^ in_f.
REQ-023 Mode 01 MISR: next = (state<<1) ^ (state[WIDTH-1] ? POLY : 0) ^ in_f.
REQ-024 Mode 10 LFSR: next = (state<<1) ^ (state[WIDTH-1] ? POLY : 0); in ignored.
REQ-025 Mode 11 HOLD: next = state; counter still decrements.
REQ-026 All-zero state in LFSR mode SHALL remain zero (no lock-up escape).
REQ-027 pass SHALL equal done && (state == captured expected).
REQ-028 State SHALL hold in IDLE and DONE; DONE persists until start or reset.

Reset
REQ-029 reset SHALL take priority over start, force IDLE, state=0, counter=0, captured regs=0, at any time including mid-RUN.
REQ-030 After reset: out=0, signature=0, busy=0, done=0, pass=0.

Structure
REQ-031 Package bench_seq_pkg SHALL hold mode enum (XOR, MISR, LFSR, HOLD), FSM state enum, and default POLY constant.
REQ-032 Combinational fold and next-state logic SHALL be sub-module bench_seq_next; FSM, counter and registers stay in bench_seq_misr.

Verification
REQ-033 Reset, start mode=00 seed=0 len=3 in=18'h00001 -> done after 4 cycles, signature=16'h0001, out=1.
REQ-034 Mode=00 seed=0 len=1 in=18'h30000 -> signature=16'h0003 (fold of upper bits).
REQ-035 Mode=10 seed=16'h8000 len=1 expected=16'hB400 -> signature=16'hB400, pass=1.
REQ-036 len=0 seed=16'h1234 expected=16'h1234 -> done next cycle, busy never 1, pass=1.
REQ-037 len=5, reset asserted after 2nd update -> next cycle IDLE, signature=0, busy=0, done=0.
REQ-038 During RUN (len=4), pulse start with seed=16'hFFFF, mode=11 -> ignored; run finishes in original mode, signature unaffected.
